vga_timing_rx: RTL and testbench
================================

VGA_TIMING_RX -- requirements
Module: vga_timing_rx

Interface
REQ-001 The module SHALL have parameter H_LIMIT, default 4095: maximum clocks between hsync rising edges before loss of sync.
REQ-002 The module SHALL have parameter V_LIMIT, default 1023: maximum lines between vsync rising edges before loss of sync.
REQ-003 The module SHALL have port clk, input, 1, the single rising-edge clock, equal to the pixel clock of the sync source.
REQ-004 The module SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 The module SHALL have port hsync_in, input, 1: active-high horizontal sync, synchronous to clk.
REQ-006 The module SHALL have port vsync_in, input, 1: active-high vertical sync, synchronous to clk.
REQ-007 The module SHALL have port video_on_in, input, 1: active-high active-video flag, synchronous to clk.
REQ-008 The module SHALL have port pixel_x, output, 16: active-pixel index within the line.
REQ-009 The module SHALL have port pixel_y, output, 16: active-line index within the frame.
REQ-010 The module SHALL have port pixel_valid, output, 1: pixel_x and pixel_y address a visible pixel.
REQ-011 The module SHALL have port line_start, output, 1: one-cycle pulse on each hsync rising edge.
REQ-012 The module SHALL have port frame_start, output, 1: one-cycle pulse on each vsync rising edge.
REQ-013 The module SHALL have port locked, output, 1: timing is verified stable.
REQ-014 The module SHALL have port h_total and v_total, outputs, 16 each: locked clocks per line and lines per frame.
REQ-015 The module SHALL have port sync_error, output, 1: one-cycle pulse when lock is lost.

Function
REQ-016 The block SHALL register all three inputs once; edge detection compares the registered value with its previous registered value.
REQ-017 The hsync rising-edge line-length counter SHALL hold clocks since the previous hsync rising edge, reload to 1 on each edge, and saturate at H_LIMIT+1.
REQ-018 The line counter SHALL increment on each hsync rising edge, reload to 1 on the vsync rising edge, and saturate at V_LIMIT+1.
REQ-019 The block SHALL implement an FSM with states SEARCH, MEASURE, VERIFY and LOCKED; the reset state SHALL be SEARCH.
REQ-020 SEARCH SHALL go to MEASURE on a vsync rising edge; MEASURE SHALL capture the first line length in that frame into internal h_meas.
REQ-021 During MEASURE, any line length differing from h_meas SHALL return the FSM to SEARCH without a sync_error pulse.
REQ-022 On the next vsync rising edge, MEASURE SHALL capture the line count into v_meas and go to VERIFY.
REQ-023 VERIFY SHALL check every line length against h_meas and the next frame's line count against v_meas; on full match at the vsync rising edge it SHALL go to LOCKED, load h_total/v_total, and assert locked.
REQ-024 In VERIFY, a mismatch SHALL return the FSM to SEARCH without a sync_error pulse.
REQ-025 In LOCKED, a mismatched line length, mismatched frame line count, or a counter exceeding H_LIMIT or V_LIMIT SHALL pulse sync_error for one cycle, deassert locked in that cycle, and enter SEARCH.
REQ-026 In any state, counter saturation SHALL force SEARCH.
REQ-027 A simultaneous hsync and vsync rising edge SHALL count as a line end and a frame end in the same cycle: line length is checked first, then line count.
REQ-028 pixel_x SHALL be 0 on the first registered video_on_in-high cycle of a line, increment per further high cycle, and reset to 0 whenever registered video_on_in is low.
REQ-029 pixel_y SHALL be 0 from the vsync rising edge and increment on each falling edge of registered video_on_in.
REQ-030 pixel_valid SHALL equal registered video_on_in AND locked; total latency from input to pixel_valid/pixel_x SHALL be 2 clocks (input register plus output register).
REQ-031 line_start and frame_start SHALL assert 2 clocks after the input edge, independent of lock.
REQ-032 All arithmetic SHALL be unsigned 16-bit; counters SHALL NOT wrap.

Reset
REQ-033 While reset_n=0, all outputs SHALL be 0, FSM SHALL be SEARCH, and all counters and measured values SHALL be 0.
REQ-034 Deassertion mid-frame SHALL require a fresh full SEARCH, MEASURE, VERIFY sequence before locked.

Verification
REQ-035 Drive 800x600 source timing (1056 clocks/line, 625 lines, hsync 80 clk, vsync 3 lines) -> locked rises at the 3rd vsync edge, h_total=1056, v_total=625.
REQ-036 Locked steady frames -> first pixel_valid has x=0,y=0; last has x=799,y=599; exactly 480000 valid cycles per frame.
REQ-037 While locked, shorten one line to 1055 clocks -> sync_error pulses once, locked=0, relock after 2 further clean frames.
REQ-038 Hold hsync_in low for 4100 clocks -> saturation, locked=0, FSM in SEARCH, no pixel_valid.
REQ-039 Assert reset_n low mid-line for 3 clocks while locked -> all outputs 0 immediately; relock needs 3 vsync edges.
REQ-040 Change line length in the MEASURE frame -> no sync_error, no locked, return to SEARCH.

Source files
------------

// File: rtl/vga_timing_rx.sv
`timescale 1ns/1ps
// VGA timing receiver: measures line and frame geometry from incoming syncs,
// locks once a full frame confirms the measurement, and emits pixel coordinates.
module vga_timing_rx #(
    parameter int unsigned H_LIMIT = 4095,
    parameter int unsigned V_LIMIT = 1023
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        video_on_in,
    output logic [15:0] pixel_x,
    output logic [15:0] pixel_y,
    output logic        pixel_valid,
    output logic        line_start,
    output logic        frame_start,
    output logic        locked,
    output logic [15:0] h_total,
    output logic [15:0] v_total,
    output logic        sync_error
);

    typedef enum logic [1:0] {SEARCH, MEASURE, VERIFY, LOCKED} state_t;

    localparam logic [15:0] H_SAT = 16'(H_LIMIT + 1);
    localparam logic [15:0] V_SAT = 16'(V_LIMIT + 1);

    state_t      state;
    state_t      next_state;
    logic        hs_r, vs_r, vo_r;
    logic        hs_p, vs_p, vo_p;
    logic        hs_rise, vs_rise, vo_fall;
    logic [15:0] h_cnt, v_cnt;
    logic [15:0] h_meas, v_meas;
    logic        h_have;
    logic        h_sat, v_sat;
    logic        lock_fail;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hs_r <= 1'b0;
            vs_r <= 1'b0;
            vo_r <= 1'b0;
            hs_p <= 1'b0;
            vs_p <= 1'b0;
            vo_p <= 1'b0;
        end else begin
            hs_r <= hsync_in;
            vs_r <= vsync_in;
            vo_r <= video_on_in;
            hs_p <= hs_r;
            vs_p <= vs_r;
            vo_p <= vo_r;
        end
    end

    assign hs_rise = hs_r & ~hs_p;
    assign vs_rise = vs_r & ~vs_p;
    assign vo_fall = ~vo_r & vo_p;
    assign h_sat   = (h_cnt == H_SAT);
    assign v_sat   = (v_cnt == V_SAT);

    // At a vsync edge, h_cnt and v_cnt still hold the length of the line and
    // frame that just ended; the reload takes effect on the same clock.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            if (hs_rise)
                h_cnt <= 16'd1;
            else if (!h_sat)
                h_cnt <= h_cnt + 16'd1;

            if (vs_rise)
                v_cnt <= 16'd1;
            else if (hs_rise && !v_sat)
                v_cnt <= v_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= SEARCH;
        else
            state <= next_state;
    end

    // Line length is judged before frame length, so a bad line on a
    // simultaneous hsync/vsync edge wins.
    always_comb begin
        next_state = state;
        lock_fail  = 1'b0;
        case (state)
            SEARCH: begin
                if (vs_rise)
                    next_state = MEASURE;
            end
            MEASURE: begin
                if (hs_rise && h_have && (h_cnt != h_meas))
                    next_state = SEARCH;
                else if (vs_rise)
                    next_state = (h_have || hs_rise) ? VERIFY : SEARCH;
            end
            VERIFY: begin
                if (hs_rise && (h_cnt != h_meas))
                    next_state = SEARCH;
                else if (vs_rise)
                    next_state = (v_cnt == v_meas) ? LOCKED : SEARCH;
            end
            LOCKED: begin
                if ((hs_rise && (h_cnt != h_total)) || (vs_rise && (v_cnt != v_total))) begin
                    next_state = SEARCH;
                    lock_fail  = 1'b1;
                end
            end
            default: next_state = SEARCH;
        endcase
        if (h_sat || v_sat) begin
            next_state = SEARCH;
            lock_fail  = (state == LOCKED);
        end
    end

    always_comb begin
        locked = (state == LOCKED);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_meas  <= '0;
            v_meas  <= '0;
            h_have  <= 1'b0;
            h_total <= '0;
            v_total <= '0;
        end else begin
            if ((state == MEASURE) && hs_rise && !h_have)
                h_meas <= h_cnt;
            h_have <= ((state == MEASURE) && (next_state == MEASURE)) ? (h_have | hs_rise) : 1'b0;
            if ((state == MEASURE) && (next_state == VERIFY))
                v_meas <= v_cnt;
            if ((state == VERIFY) && (next_state == LOCKED)) begin
                h_total <= h_meas;
                v_total <= v_meas;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            sync_error  <= 1'b0;
            pixel_valid <= 1'b0;
            pixel_x     <= '0;
            pixel_y     <= '0;
        end else begin
            line_start  <= hs_rise;
            frame_start <= vs_rise;
            sync_error  <= lock_fail;
            pixel_valid <= vo_r & locked;

            if (vo_r && vo_p)
                pixel_x <= (pixel_x == 16'hFFFF) ? pixel_x : pixel_x + 16'd1;
            else
                pixel_x <= '0;

            if (vs_rise)
                pixel_y <= '0;
            else if (vo_fall && (pixel_y != 16'hFFFF))
                pixel_y <= pixel_y + 16'd1;
        end
    end

endmodule

// File: tb/tb_vga_timing_rx.sv
`timescale 1ns/1ps
// Bench for vga_timing_rx: a scaled 64x24 timing (40x16 visible) with a
// per-frame scoreboard checked at each frame_start.
module tb_vga_timing_rx;

    localparam int LINE_LEN = 64;
    localparam int FRAME_LINES = 24;
    localparam int VIS_PIX = 40;
    localparam int VIS_LINES = 16;

    logic        clk;
    logic        reset_n;
    logic        hsync_in, vsync_in, video_on_in;
    logic [15:0] pixel_x, pixel_y, h_total, v_total;
    logic        pixel_valid, line_start, frame_start, locked, sync_error;

    typedef struct {
        bit lock;
        int prev_valid;
        int prev_lines;
        int t;
    } exp_t;

    exp_t exp_q[$];
    exp_t rec;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   valid_cnt, line_cnt, err_cnt, valid_total;
    logic [15:0] first_x, first_y, last_x, last_y;
    int   snap;

    vga_timing_rx dut (
        .clk(clk),
        .reset_n(reset_n),
        .hsync_in(hsync_in),
        .vsync_in(vsync_in),
        .video_on_in(video_on_in),
        .pixel_x(pixel_x),
        .pixel_y(pixel_y),
        .pixel_valid(pixel_valid),
        .line_start(line_start),
        .frame_start(frame_start),
        .locked(locked),
        .h_total(h_total),
        .v_total(v_total),
        .sync_error(sync_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs();
        check_output("rst_pixel_x", 32'(pixel_x), 0);
        check_output("rst_pixel_y", 32'(pixel_y), 0);
        check_output("rst_pixel_valid", 32'(pixel_valid), 0);
        check_output("rst_line_start", 32'(line_start), 0);
        check_output("rst_frame_start", 32'(frame_start), 0);
        check_output("rst_locked", 32'(locked), 0);
        check_output("rst_h_total", 32'(h_total), 0);
        check_output("rst_v_total", 32'(v_total), 0);
        check_output("rst_sync_error", 32'(sync_error), 0);
    endtask

    // Each frame_start pops the expectation pushed when its vsync edge was driven.
    always @(negedge clk) begin
        if (!reset_n) begin
            valid_cnt = 0;
            line_cnt  = 0;
        end else begin
            if (frame_start) begin
                if (exp_q.size() == 0) begin
                    check_output("frame_start_unexpected", 32'(frame_start), 0);
                end else begin
                    rec = exp_q.pop_front();
                    check_output("frame_start_latency", 32'(cyc - rec.t), 2);
                    check_output("locked_at_frame_start", 32'(locked), 32'(rec.lock));
                    if (rec.lock) begin
                        check_output("h_total", 32'(h_total), LINE_LEN);
                        check_output("v_total", 32'(v_total), FRAME_LINES);
                    end
                    if (rec.prev_valid >= 0)
                        check_output("valid_per_frame", 32'(valid_cnt), 32'(rec.prev_valid));
                    if (rec.prev_valid > 0) begin
                        check_output("first_x", 32'(first_x), 0);
                        check_output("first_y", 32'(first_y), 0);
                        check_output("last_x", 32'(last_x), VIS_PIX - 1);
                        check_output("last_y", 32'(last_y), 32'(rec.prev_valid / VIS_PIX - 1));
                    end
                    if (rec.prev_lines >= 0)
                        check_output("lines_per_frame", 32'(line_cnt), 32'(rec.prev_lines));
                end
                valid_cnt = 0;
                line_cnt  = 0;
            end
            if (line_start)
                line_cnt++;
            if (pixel_valid) begin
                if (valid_cnt == 0) begin
                    first_x = pixel_x;
                    first_y = pixel_y;
                end
                last_x = pixel_x;
                last_y = pixel_y;
                valid_cnt++;
                valid_total++;
            end
            if (sync_error)
                err_cnt++;
        end
    end

    // One frame; optionally one line of altered length and a 3-clock reset pulse.
    task automatic apply_stimulus(input int short_line, input int short_len, input bit lock_exp,
                                  input int prev_valid, input int prev_lines,
                                  input int rst_line, input int rst_cyc);
        for (int l = 0; l < FRAME_LINES; l++) begin
            int len;
            len = (l == short_line) ? short_len : LINE_LEN;
            for (int c = 0; c < len; c++) begin
                @(negedge clk);
                hsync_in    = (c < 8);
                vsync_in    = (l < 3);
                video_on_in = (l >= 5) && (l < 5 + VIS_LINES) && (c >= 16) && (c < 16 + VIS_PIX);
                if (l == 0 && c == 0)
                    exp_q.push_back('{lock_exp, prev_valid, prev_lines, cyc});
                if (l == rst_line && c == rst_cyc) begin
                    reset_n = 1'b0;
                    #1;
                    check_reset_outputs();
                end
                if (l == rst_line && c == rst_cyc + 3)
                    reset_n = 1'b1;
            end
        end
    endtask

    task automatic stall_hsync(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            hsync_in    = 1'b0;
            vsync_in    = 1'b0;
            video_on_in = (c >= n - 40);
        end
        for (int l = 0; l < 2; l++) begin
            for (int c = 0; c < LINE_LEN; c++) begin
                @(negedge clk);
                hsync_in    = (c < 8);
                vsync_in    = 1'b0;
                video_on_in = 1'b0;
            end
        end
    endtask

    initial begin
        valid_cnt   = 0;
        line_cnt    = 0;
        err_cnt     = 0;
        valid_total = 0;
        reset_n     = 1'b0;
        hsync_in    = 1'b0;
        vsync_in    = 1'b0;
        video_on_in = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs();
        @(negedge clk);
        reset_n = 1'b1;

        // Line length disturbed inside the measuring frame: silent fallback, later lock.
        apply_stimulus(12, 60, 1'b0, -1, -1, -1, -1);
        #1 check_output("no_err_measure_fault", 32'(err_cnt), 0);
        apply_stimulus(-1, 0, 1'b0, 0, FRAME_LINES, -1, -1);
        apply_stimulus(-1, 0, 1'b0, 0, FRAME_LINES, -1, -1);
        apply_stimulus(-1, 0, 1'b1, 0, FRAME_LINES, -1, -1);
        apply_stimulus(-1, 0, 1'b1, VIS_PIX * VIS_LINES, FRAME_LINES, -1, -1);

        // One 63-clock line while locked.
        apply_stimulus(10, LINE_LEN - 1, 1'b1, VIS_PIX * VIS_LINES, FRAME_LINES, -1, -1);
        #1 check_output("sync_error_short_line", 32'(err_cnt), 1);
        check_output("locked_after_short_line", 32'(locked), 0);
        apply_stimulus(-1, 0, 1'b0, VIS_PIX * 6, FRAME_LINES, -1, -1);
        apply_stimulus(-1, 0, 1'b0, 0, FRAME_LINES, -1, -1);
        apply_stimulus(-1, 0, 1'b1, 0, FRAME_LINES, -1, -1);
        apply_stimulus(-1, 0, 1'b1, VIS_PIX * VIS_LINES, FRAME_LINES, -1, -1);

        // hsync held low long enough to saturate the line counter.
        snap = valid_total;
        stall_hsync(4100);
        #1 check_output("sync_error_saturation", 32'(err_cnt), 2);
        check_output("locked_after_saturation", 32'(locked), 0);
        check_output("no_valid_during_stall", 32'(valid_total - snap), 0);
        apply_stimulus(-1, 0, 1'b0, VIS_PIX * VIS_LINES, FRAME_LINES + 2, -1, -1);
        apply_stimulus(-1, 0, 1'b0, 0, FRAME_LINES, -1, -1);
        apply_stimulus(-1, 0, 1'b1, 0, FRAME_LINES, -1, -1);

        // Reset mid-line while locked and showing pixels.
        apply_stimulus(-1, 0, 1'b1, VIS_PIX * VIS_LINES, FRAME_LINES, 8, 30);
        apply_stimulus(-1, 0, 1'b0, -1, -1, -1, -1);
        apply_stimulus(-1, 0, 1'b0, 0, FRAME_LINES, -1, -1);
        apply_stimulus(-1, 0, 1'b1, 0, FRAME_LINES, -1, -1);
        apply_stimulus(-1, 0, 1'b1, VIS_PIX * VIS_LINES, FRAME_LINES, -1, -1);

        repeat (5) @(negedge clk);
        #1 check_output("pending_frame_starts", 32'(exp_q.size()), 0);
        check_output("total_sync_errors", 32'(err_cnt), 2);
        check_output("locked_at_end", 32'(locked), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
